// File: rtl/mlb_loader_if.sv
// Stream-in handshake plus MLB write-port bundle for the MLB loader.
// master = loader side (drives ready and the MLB write bus); slave = producer/MLB side.
interface mlb_loader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;
  logic [DATA_W-1:0] out4;
  logic [DATA_W-1:0] out5;
  logic [DATA_W-1:0] out6;
  logic [DATA_W-1:0] out7;
  logic [DATA_W-1:0] out8;
  logic [DATA_W-1:0] out9;
  logic [DATA_W-1:0] out10;
  logic [DATA_W-1:0] out11;
  logic [DATA_W-1:0] out12;
  logic [DATA_W-1:0] out13;
  logic [DATA_W-1:0] out14;
  logic [DATA_W-1:0] out15;
  logic              write_en;
  logic              read_en;
  logic [1:0]        sub_tile_idx;
  logic [2:0]        unit_tile_idx;

  modport master (
    input  in_data, in_valid,
    output in_ready,
    output out0, out1, out2, out3, out4, out5, out6, out7,
    output out8, out9, out10, out11, out12, out13, out14, out15,
    output write_en, read_en, sub_tile_idx, unit_tile_idx
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready,
    input  out0, out1, out2, out3, out4, out5, out6, out7,
    input  out8, out9, out10, out11, out12, out13, out14, out15,
    input  write_en, read_en, sub_tile_idx, unit_tile_idx
  );
endinterface

// File: rtl/mlb_loader.sv
// MLB write-side producer: packs 16 stream words per unit-tile line and issues one
// MLB write per line for 1..4 sub-tiles, then pulses done.
module mlb_loader #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int UNIT_TILES = 8,
  parameter int SUB_TILES  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   num_sub_tiles,
  input  logic         abort,
  mlb_loader_if.master bus,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] word_cnt_reg, word_cnt_next;
  logic [1:0] sub_reg, sub_next;
  logic [2:0] unit_reg, unit_next;
  logic [1:0] last_sub_reg, last_sub_next;
  logic       in_ready_reg;
  logic       write_en_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       handshake;
  logic       last_line;

  // in_ready_reg is high exactly while in FILL, so it doubles as the FILL qualifier
  assign handshake = bus.in_valid & in_ready_reg;
  assign last_line = (sub_reg == last_sub_reg) && (unit_reg == 3'(UNIT_TILES - 1));

  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    sub_next      = sub_reg;
    unit_next     = unit_reg;
    last_sub_next = last_sub_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (num_sub_tiles == 3'd0) begin
            state_next = DONE;
          end else begin
            state_next    = FILL;
            sub_next      = 2'd0;
            unit_next     = 3'd0;
            word_cnt_next = 4'd0;
            // requests beyond the MLB capacity are clamped to the full buffer
            last_sub_next = (num_sub_tiles > 3'(SUB_TILES)) ? 2'(SUB_TILES - 1)
                                                            : 2'(num_sub_tiles - 3'd1);
          end
        end
      end
      FILL: begin
        if (abort) begin
          state_next = IDLE;
        end else if (handshake) begin
          word_cnt_next = word_cnt_reg + 4'd1;
          if (word_cnt_reg == 4'(LINE_WORDS - 1)) begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last_line) begin
          state_next = DONE;
        end else begin
          state_next    = FILL;
          word_cnt_next = 4'd0;
          if (unit_reg == 3'(UNIT_TILES - 1)) begin
            unit_next = 3'd0;
            sub_next  = sub_reg + 2'd1;
          end else begin
            unit_next = unit_reg + 3'd1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      word_cnt_reg <= 4'd0;
      sub_reg      <= 2'd0;
      unit_reg     <= 3'd0;
      last_sub_reg <= 2'd0;
      in_ready_reg <= 1'b0;
      write_en_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      sub_reg      <= sub_next;
      unit_reg     <= unit_next;
      last_sub_reg <= last_sub_next;
      in_ready_reg <= (state_next == FILL);
      write_en_reg <= (state_next == WRITE);
      busy_reg     <= (state_next == FILL) || (state_next == WRITE);
      done_reg     <= (state_next == DONE);
    end
  end

  // One register per MLB lane; lane gi captures the word whose index in the line is gi
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_lane
    logic [DATA_W-1:0] lane_reg;
    always_ff @(posedge clk) begin
      if (!rst) begin
        lane_reg <= '0;
      end else if (handshake && (word_cnt_reg == 4'(gi))) begin
        lane_reg <= bus.in_data;
      end
    end
  end

  assign bus.out0  = g_lane[0].lane_reg;
  assign bus.out1  = g_lane[1].lane_reg;
  assign bus.out2  = g_lane[2].lane_reg;
  assign bus.out3  = g_lane[3].lane_reg;
  assign bus.out4  = g_lane[4].lane_reg;
  assign bus.out5  = g_lane[5].lane_reg;
  assign bus.out6  = g_lane[6].lane_reg;
  assign bus.out7  = g_lane[7].lane_reg;
  assign bus.out8  = g_lane[8].lane_reg;
  assign bus.out9  = g_lane[9].lane_reg;
  assign bus.out10 = g_lane[10].lane_reg;
  assign bus.out11 = g_lane[11].lane_reg;
  assign bus.out12 = g_lane[12].lane_reg;
  assign bus.out13 = g_lane[13].lane_reg;
  assign bus.out14 = g_lane[14].lane_reg;
  assign bus.out15 = g_lane[15].lane_reg;

  assign bus.in_ready      = in_ready_reg;
  assign bus.write_en      = write_en_reg;
  assign bus.read_en       = 1'b0;
  assign bus.sub_tile_idx  = sub_reg;
  assign bus.unit_tile_idx = unit_reg;
  assign busy              = busy_reg;
  assign done              = done_reg;

endmodule

// File: tb/tb_mlb_loader.sv
// Self-checking bench for mlb_loader: table of load vectors, a line scoreboard fed
// by the stream driver, and hand-written abort / reset / idle sequences.
module tb_mlb_loader;

  typedef struct {
    logic [1:0]  sub;
    logic [2:0]  unit;
    logic [31:0] lane [16];
  } line_t;

  typedef struct {
    logic [2:0] num;
    bit         rnd;
    int         lines;
    int         poke;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] num_sub_tiles;
  logic       abort;
  logic       busy;
  logic       done;

  mlb_loader_if bus ();

  mlb_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_sub_tiles (num_sub_tiles),
    .abort         (abort),
    .bus           (bus),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] obs [16];
  assign obs[0]  = bus.out0;
  assign obs[1]  = bus.out1;
  assign obs[2]  = bus.out2;
  assign obs[3]  = bus.out3;
  assign obs[4]  = bus.out4;
  assign obs[5]  = bus.out5;
  assign obs[6]  = bus.out6;
  assign obs[7]  = bus.out7;
  assign obs[8]  = bus.out8;
  assign obs[9]  = bus.out9;
  assign obs[10] = bus.out10;
  assign obs[11] = bus.out11;
  assign obs[12] = bus.out12;
  assign obs[13] = bus.out13;
  assign obs[14] = bus.out14;
  assign obs[15] = bus.out15;

  int    vectors    = 0;
  int    miscompares = 0;
  line_t sb [$];
  line_t mon_e;
  int    wr_total    = 0;
  int    last_wr_cyc = 0;
  int    start_cyc   = 0;
  bit    spacing_on  = 1'b0;
  bit    have_prev   = 1'b0;
  vec_t  vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: every write_en cycle must match the oldest expected line
  always @(negedge clk) begin
    if (bus.write_en === 1'b1) begin
      wr_total++;
      if (spacing_on && have_prev) chk("write_spacing", 64'(cyc - last_wr_cyc), 64'd17);
      have_prev   = 1'b1;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got write_en=1 sub=%0d unit=%0d out0=%0h, expected no write (cycle %0d)",
                 bus.sub_tile_idx, bus.unit_tile_idx, bus.out0, cyc);
      end else begin
        int nbad;
        mon_e = sb.pop_front();
        nbad = 0;
        for (int j = 0; j < 16; j++) if (obs[j] !== mon_e.lane[j]) nbad++;
        $display("write cyc=%0d sub=%0d unit=%0d out0=%0d out15=%0d", cyc,
                 bus.sub_tile_idx, bus.unit_tile_idx, bus.out0, bus.out15);
        chk("write_sub", 64'(bus.sub_tile_idx), 64'(mon_e.sub));
        chk("write_unit", 64'(bus.unit_tile_idx), 64'(mon_e.unit));
        chk("write_out0", 64'(bus.out0), 64'(mon_e.lane[0]));
        chk("write_out15", 64'(bus.out15), 64'(mon_e.lane[15]));
        chk("write_bad_lanes", 64'(nbad), 64'd0);
      end
    end
  end

  task automatic push_line(input int l, input int base);
    line_t e;
    e.sub  = 2'(l / 8);
    e.unit = 3'(l % 8);
    for (int j = 0; j < 16; j++) e.lane[j] = 32'(base + 16 * l + j);
    sb.push_back(e);
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance
  task automatic drive_word(input logic [31:0] data, input bit rnd);
    bit hs;
    if (rnd) begin
      int gaps;
      gaps = int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    hs = 1'b0;
    for (int t = 0; t < 200; t++) begin
      hs = bus.in_ready;
      @(negedge clk);
      if (hs) break;
    end
    if (!hs) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: got in_ready=0 for 200 cycles, expected acceptance of word %0d", data);
    end
  endtask

  task automatic stream(input int nlines, input int base, input bit rnd, input int poke, input int extra);
    for (int l = 0; l < nlines + ((extra > 0) ? 1 : 0); l++) begin
      int nw;
      nw = (l < nlines) ? 16 : extra;
      for (int j = 0; j < nw; j++) begin
        if (l < nlines && j == 15) push_line(l, base);
        if (l == poke && j == 0) begin
          start         = 1'b1;
          num_sub_tiles = 3'd4;
        end
        drive_word(32'(base + 16 * l + j), rnd);
        start = 1'b0;
      end
    end
  endtask

  task automatic start_load(input logic [2:0] num);
    start         = 1'b1;
    num_sub_tiles = num;
    start_cyc     = cyc + 1;
    have_prev     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(num != 3'd0));
  endtask

  task automatic finish_load(input int lines, input int wr0);
    bit found;
    int dcyc;
    found = 1'b0;
    dcyc  = 0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        dcyc  = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 64'(found), 64'd1);
    if (found) begin
      chk("done_cycle", 64'(dcyc), 64'((lines > 0) ? last_wr_cyc + 1 : start_cyc));
      chk("busy_at_done", 64'(busy), 64'd0);
      if (lines > 0) begin
        chk("final_sub", 64'(bus.sub_tile_idx), 64'((lines - 1) / 8));
        chk("final_unit", 64'(bus.unit_tile_idx), 64'((lines - 1) % 8));
      end
    end
    chk("load_writes", 64'(wr_total - wr0), 64'(lines));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    logic [31:0] lane_or;
    lane_or = '0;
    for (int j = 0; j < 16; j++) lane_or |= obs[j];
    chk({name, "_ctrl"}, 64'({bus.write_en, bus.read_en, bus.in_ready, bus.sub_tile_idx,
                              bus.unit_tile_idx, busy, done}), 64'd0);
    chk({name, "_lanes"}, 64'(lane_or), 64'd0);
  endtask

  // Lines 0..2 complete, then 8 words of line 3 left hanging
  task automatic partial_load(output int wr0);
    spacing_on = 1'b1;
    wr0 = wr_total;
    start_load(3'd2);
    stream(3, 0, 1'b0, -1, 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    bit seen;
    vecs[0] = '{num: 3'd1, rnd: 1'b0, lines: 8,  poke: -1};
    vecs[1] = '{num: 3'd4, rnd: 1'b0, lines: 32, poke: -1};
    vecs[2] = '{num: 3'd7, rnd: 1'b0, lines: 32, poke: -1};
    vecs[3] = '{num: 3'd2, rnd: 1'b1, lines: 16, poke: -1};
    vecs[4] = '{num: 3'd0, rnd: 1'b0, lines: 0,  poke: -1};
    vecs[5] = '{num: 3'd1, rnd: 1'b0, lines: 8,  poke: 3};

    rst           = 1'b0;
    start         = 1'b0;
    num_sub_tiles = 3'd0;
    abort         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      $display("load num=%0d rnd=%0d lines=%0d poke=%0d", vecs[v].num, vecs[v].rnd, vecs[v].lines, vecs[v].poke);
      spacing_on = !vecs[v].rnd;
      wr0 = wr_total;
      start_load(vecs[v].num);
      stream(vecs[v].lines, 0, vecs[v].rnd, vecs[v].poke, 0);
      finish_load(vecs[v].lines, wr0);
      @(negedge clk);
    end

    $display("abort after word 7 of line 3");
    partial_load(wr0);
    abort        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_writes", 64'(wr_total - wr0), 64'd3);
    chk("abort_sb_empty", 64'(sb.size()), 64'd0);

    $display("fresh load after abort");
    spacing_on = 1'b1;
    wr0 = wr_total;
    start_load(3'd1);
    stream(8, 1000, 1'b0, -1, 0);
    finish_load(8, wr0);

    $display("reset during line 3");
    partial_load(wr0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_all_zero("midload_reset");
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("reset_writes", 64'(wr_total - wr0), 64'd3);
    chk("reset_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
